pixel_array_sequencer: RTL
==========================

// Module: pixel_array_sequencer
// PURPOSE
//  Digital sequencer and readout for a parametrised array of N_PIX pixel sensors. It
//  drives the shared ERASE/EXPOSE/convert controls and generates the DW-bit ramp-code
//  counter that pixels latch during conversion. It then reads the pixels one by one
//  over the shared data bus and emits each sample on a valid/ready stream.
//  It sits between the analog pixel array and the frame buffer/host interface, and
//  adds single-shot and continuous frame modes plus runtime exposure length.
// PARAMETERS
//  N_PIX       4   number of pixels (>=1); sets pix_read width and out_idx range
//  DW          8   data bus / ramp-code width; convert phase lasts 2**DW cycles
//  T_ERASE     5   cycles pix_erase is held high (>=1)
//  READ_SETUP  2   cycles pix_read[i] is high before data_in is sampled (>=1)
//  IW          2   out_idx width, >= clog2(N_PIX) (min 1)
// PORTS
//  clk         in   1      clock
//  reset       in   1      asynchronous active-low reset
//  start       in   1      start one frame (pulse, sampled in IDLE only)
//  continuous  in   1      1: loop frames back-to-back; sampled at end of READ phase
//  cfg_expose  in   16     exposure length in cycles, latched at frame start; 0 -> 1
//  pix_erase   out  1      pixel erase control
//  pix_expose  out  1      pixel expose control
//  pix_convert out  1      ramp active; the array latches cnt_out on comparator flip
//  cnt_out     out  DW     ramp-code counter, driven to the data bus while cnt_oe=1
//  cnt_oe      out  1      counter drives the shared bus (equals pix_convert)
//  pix_read    out  N_PIX  one-hot read select
//  data_in     in   DW     shared data bus as seen from the pixels
//  out_data    out  DW     sampled pixel code
//  out_idx     out  IW     pixel index of out_data
//  out_valid   out  1      out_data/out_idx valid
//  out_ready   in   1      consumer accepts on out_valid && out_ready
//  busy        out  1      high in every state except IDLE
//  frame_done  out  1      one-cycle pulse when the last pixel of a frame is accepted
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; all outputs 0; counters cleared. Reset
//   mid-frame aborts immediately: no partial stream completion, no frame_done.
//  FSM: IDLE -> ERASE -> EXPOSE -> CONVERT -> READ -> (ERASE | IDLE).
//  IDLE: start=1 latches cfg_expose (0 -> 1) and enters ERASE next cycle. start is
//   ignored in every other state.
//  ERASE: pix_erase=1 for exactly T_ERASE cycles.
//  EXPOSE: pix_expose=1 for exactly the latched exposure count of cycles.
//  CONVERT: pix_convert=cnt_oe=1 for 2**DW cycles. cnt_out=0 on the first cycle and
//   increments by 1 per cycle up to 2**DW-1 on the last cycle. No wrap. cnt_out
//   returns to 0 when CONVERT is left.
//  READ: slot i runs from 0 to N_PIX-1. pix_read = 1<<i for the whole slot.
//   - After READ_SETUP cycles in the slot, out_data<=data_in, out_idx<=i and
//     out_valid<=1 on the same edge.
//   - out_valid holds, with stable data, until out_valid&&out_ready.
//   - On the accepting edge: out_valid<=0, and pix_read moves to slot i+1, which
//     restarts the setup count.
//   - out_ready held low stalls indefinitely; there is no timeout.
//   - out_ready high before valid has no effect.
//  Last slot accepted: frame_done pulses 1 cycle and pix_read<=0.
//   - If continuous=1: next state is ERASE (cfg_expose re-latched) with no idle cycle.
//   - Else: next state is IDLE.
//   - Dropping continuous mid-frame finishes the current frame, then goes to IDLE.
//  Control outputs are registered and mutually exclusive. At most one of erase,
//   expose, convert or any pix_read bit is high in any cycle.
//  Frame length with no stall: T_ERASE + exp + 2**DW + N_PIX*(READ_SETUP+1) cycles.
// TESTING
//  1 Reset: hold reset=0 with random inputs -> every output 0. Release -> IDLE, busy=0.
//  2 Single frame, defaults, cfg_expose=10, out_ready=1, data_in=8'hA0+i in slot i:
//    -> erase high 5 cycles, expose high 10, convert high 256 with cnt_out 0..255;
//    -> out stream (0,A0),(1,A1),(2,A2),(3,A3), each valid 2 cycles after its read starts;
//    -> frame_done once, then IDLE.
//  3 Backpressure: out_ready=0 for 20 cycles in slot 1 -> pix_read=4'b0010, out_valid=1
//    and out_data stable throughout. Raise ready -> advances to slot 2 next cycle.
//  4 cfg_expose=0 -> expose high exactly 1 cycle. Start pulsed during CONVERT -> ignored.
//  5 continuous=1 for 3 frames, dropped during frame 3 EXPOSE -> 3 frame_done pulses,
//    ERASE directly follows READ, IDLE after frame 3.
//  6 reset=0 mid-READ at slot 2 -> outputs 0 asynchronously; no frame_done; next start
//    begins from ERASE with slot 0.

Source files
------------

// File: rtl/pixel_array_sequencer.sv
// Pixel array sequencer: drives the erase/expose/convert phases, generates the
// ramp code latched by the pixels, then reads every pixel over the shared bus
// and streams the samples out with a valid/ready handshake.
module pixel_array_sequencer #(
  parameter int N_PIX      = 4,
  parameter int DW         = 8,
  parameter int T_ERASE    = 5,
  parameter int READ_SETUP = 2,
  parameter int IW         = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [15:0]      cfg_expose,
  output logic             pix_erase,
  output logic             pix_expose,
  output logic             pix_convert,
  output logic [DW-1:0]    cnt_out,
  output logic             cnt_oe,
  output logic [N_PIX-1:0] pix_read,
  input  logic [DW-1:0]    data_in,
  output logic [DW-1:0]    out_data,
  output logic [IW-1:0]    out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ
  } state_t;

  state_t        state;
  logic [15:0]   timer;    // cycles remaining in the current timed phase / setup
  logic [15:0]   exp_len;  // exposure length latched at frame start
  logic [IW-1:0] slot;     // pixel currently being read

  // A zero exposure request still exposes for one cycle.
  function automatic logic [15:0] expose_len(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  // Frame sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      timer       <= 16'd0;
      exp_len     <= 16'd1;
      slot        <= '0;
      pix_erase   <= 1'b0;
      pix_expose  <= 1'b0;
      pix_convert <= 1'b0;
      cnt_out     <= '0;
      cnt_oe      <= 1'b0;
      pix_read    <= '0;
      out_data    <= '0;
      out_idx     <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            exp_len   <= expose_len(cfg_expose);
            timer     <= 16'(T_ERASE - 1);
            pix_erase <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ERASE;
          end
        end

        S_ERASE: begin
          if (timer == 16'd0) begin
            pix_erase  <= 1'b0;
            pix_expose <= 1'b1;
            timer      <= exp_len - 16'd1;
            state      <= S_EXPOSE;
          end else begin
            timer <= timer - 16'd1;
          end
        end

        S_EXPOSE: begin
          if (timer == 16'd0) begin
            pix_expose  <= 1'b0;
            pix_convert <= 1'b1;
            cnt_oe      <= 1'b1;
            cnt_out     <= '0;
            state       <= S_CONVERT;
          end else begin
            timer <= timer - 16'd1;
          end
        end

        // The ramp ends on its all-ones code; it never wraps.
        S_CONVERT: begin
          if (cnt_out == '1) begin
            pix_convert <= 1'b0;
            cnt_oe      <= 1'b0;
            cnt_out     <= '0;
            slot        <= '0;
            pix_read    <= N_PIX'(1);
            timer       <= 16'(READ_SETUP - 1);
            state       <= S_READ;
          end else begin
            cnt_out <= cnt_out + DW'(1);
          end
        end

        // Each slot: settle for READ_SETUP cycles, sample, then wait for the
        // consumer; acceptance moves the select to the next pixel.
        S_READ: begin
          if (!out_valid) begin
            if (timer == 16'd0) begin
              out_data  <= data_in;
              out_idx   <= slot;
              out_valid <= 1'b1;
            end else begin
              timer <= timer - 16'd1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (slot == IW'(N_PIX - 1)) begin
              pix_read   <= '0;
              frame_done <= 1'b1;
              if (continuous) begin
                exp_len   <= expose_len(cfg_expose);
                timer     <= 16'(T_ERASE - 1);
                pix_erase <= 1'b1;
                state     <= S_ERASE;
              end else begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end else begin
              slot     <= slot + IW'(1);
              pix_read <= pix_read << 1;
              timer    <= 16'(READ_SETUP - 1);
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
